sda_stp_receiver: RTL and testbench

SDA_STP_RECEIVER -- requirements
Module: sda_stp_receiver

---
 rtl/stp_pkg.sv | 13 +
 rtl/line_sync.sv | 34 +++
 rtl/sda_stp_receiver.sv | 127 ++++++++++++
 tb/tb_sda_stp_receiver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stp_pkg.sv
// Shared constants and types for the serial-to-parallel receiver.
// Imported by the synchronizer and receiver top.
package stp_pkg;

  localparam int STP_DATA_WIDTH = 16;
  localparam int IDX_W = 8;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

endpackage

// File: rtl/line_sync.sv
// Multi-flop synchronizer for one bus line, with a delayed
// copy and single-cycle rise/fall flags. Idles high.
module line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic s,
  output logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '1;
      d <= 1'b1;
    end else begin
      q[0] <= line;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        q[i] <= q[i-1];
      end
      d <= q[SYNC_STAGES-1];
    end
  end

  assign s    = q[SYNC_STAGES-1];
  assign rise = s & ~d;
  assign fall = ~s & d;

endmodule

// File: rtl/sda_stp_receiver.sv
// Two-wire serial receiver: START/STOP framing, MSB-first words
// captured on SCL rises, framing errors on aborted words.
module sda_stp_receiver
  import stp_pkg::*;
#(
  parameter int DATA_WIDTH  = STP_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  STP_en,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic [IDX_W-1:0]      bit_index
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 256) begin : g_bad_width
    $error("DATA_WIDTH must be 1..256");
  end

  localparam logic [IDX_W-1:0] TOP = IDX_W'(DATA_WIDTH - 1);

  logic scl_s, scl_d, scl_rise, scl_fall;
  logic sda_s, sda_d, sda_rise, sda_fall;

  line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk  (clk),
    .rst_n(rst_n),
    .line (scl_in),
    .s    (scl_s),
    .d    (scl_d),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk  (clk),
    .rst_n(rst_n),
    .line (sda_in),
    .s    (sda_s),
    .d    (sda_d),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  logic unused_ok;
  assign unused_ok = ^{scl_fall, sda_d};

  logic scl_high, start, stop, mid;
  assign scl_high = scl_s & scl_d;
  assign start    = scl_high & sda_fall;
  assign stop     = scl_high & sda_rise;
  assign mid      = (bit_index != TOP);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word;

  // Shift register with the current bit already dropped in.
  always_comb begin
    word = shreg;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (bit_index == IDX_W'(i)) word[i] = sda_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      bit_index  <= TOP;
      shreg      <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!STP_en) begin
        state     <= IDLE;
        busy      <= 1'b0;
        bit_index <= TOP;
        shreg     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state     <= RECV;
              busy      <= 1'b1;
              shreg     <= '0;
              bit_index <= TOP;
            end
          end
          RECV: begin
            if (scl_rise) begin
              if (bit_index == '0) begin
                data_out   <= word;
                data_valid <= 1'b1;
                shreg      <= '0;
                bit_index  <= TOP;
              end else begin
                shreg     <= word;
                bit_index <= bit_index - IDX_W'(1);
              end
            end else if (start) begin
              frame_err <= mid;
              shreg     <= '0;
              bit_index <= TOP;
            end else if (stop) begin
              frame_err <= mid;
              state     <= IDLE;
              busy      <= 1'b0;
              shreg     <= '0;
              bit_index <= TOP;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sda_stp_receiver.sv
// Scoreboard bench for sda_stp_receiver: words queued at send time,
// checked when data_valid pulses.
module tb_sda_stp_receiver;

  localparam int DW = 16;
  localparam int SS = 2;
  localparam int PH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          STP_en = 1'b0;
  logic          scl_in = 1'b1;
  logic          sda_in = 1'b1;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          frame_err;
  logic [7:0]    bit_index;

  sda_stp_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .STP_en    (STP_en),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .bit_index (bit_index)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic prev_dv;
    logic prev_fe;
    prev_dv = 1'b0;
    prev_fe = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid) begin
        dv_cnt++;
        check("dv_width", 32'(prev_dv), 0);
        check("idx_reload", 32'(bit_index), DW - 1);
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (frame_err) begin
        fe_cnt++;
        check("fe_width", 32'(prev_fe), 0);
      end
      prev_dv = data_valid;
      prev_fe = frame_err;
    end
  end

  task automatic wait_ph();
    repeat (PH) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (sda_in == 1'b0) begin
      sda_in = 1'b1;
      wait_ph();
    end
    sda_in = 1'b0;
    wait_ph();
  endtask

  task automatic bus_stop();
    if (sda_in == 1'b1) begin
      sda_in = 1'b0;
      wait_ph();
    end
    sda_in = 1'b1;
    wait_ph();
  endtask

  task automatic bus_bit(input logic b, input bit lat);
    scl_in = 1'b0;
    wait_ph();
    sda_in = b;
    wait_ph();
    scl_in = 1'b1;
    for (int k = 1; k <= PH; k++) begin
      @(posedge clk);
      #1;
      if (lat && k == SS) check("lat_early", 32'(data_valid), 0);
      if (lat && k == SS + 1) check("latency", 32'(data_valid), 1);
    end
  endtask

  task automatic bus_word(input logic [DW-1:0] w, input bit push);
    if (push) exp_q.push_back(w);
    for (int i = DW - 1; i >= 0; i--) bus_bit(w[i], push && i == 0);
  endtask

  initial begin
    int dv0;
    int fe0;
    logic [4:0] b5;
    logic [5:0] b6;
    b5 = 5'b10110;
    b6 = 6'b110101;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data_out), 0);
    check("rst_dv", 32'(data_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fe", 32'(frame_err), 0);
    check("rst_idx", 32'(bit_index), DW - 1);
    rst_n = 1'b1;
    STP_en = 1'b1;
    wait_ph();

    // single word
    dv0 = dv_cnt; fe0 = fe_cnt;
    bus_start();
    check("t1_busy", 32'(busy), 1);
    bus_word(16'hA5C3, 1'b1);
    bus_stop();
    check("t1_dv", 32'(dv_cnt - dv0), 1);
    check("t1_fe", 32'(fe_cnt - fe0), 0);
    check("t1_busy_off", 32'(busy), 0);
    check("t1_data", 32'(data_out), 32'h A5C3);

    // back-to-back words
    dv0 = dv_cnt; fe0 = fe_cnt;
    bus_start();
    bus_word(16'h1234, 1'b1);
    check("t2_idx", 32'(bit_index), DW - 1);
    bus_word(16'hFFFF, 1'b1);
    check("t2_idx2", 32'(bit_index), DW - 1);
    bus_stop();
    check("t2_dv", 32'(dv_cnt - dv0), 2);
    check("t2_fe", 32'(fe_cnt - fe0), 0);

    // STOP mid-word
    dv0 = dv_cnt; fe0 = fe_cnt;
    bus_start();
    for (int i = 4; i >= 0; i--) bus_bit(b5[i], 1'b0);
    check("t3_idx", 32'(bit_index), DW - 6);
    bus_stop();
    check("t3_fe", 32'(fe_cnt - fe0), 1);
    check("t3_dv", 32'(dv_cnt - dv0), 0);
    check("t3_hold", 32'(data_out), 32'h FFFF);
    check("t3_busy", 32'(busy), 0);

    // repeated START mid-word
    dv0 = dv_cnt; fe0 = fe_cnt;
    bus_start();
    for (int i = 0; i < 7; i++) bus_bit(1'b1, 1'b0);
    bus_start();
    check("t4_fe_mid", 32'(fe_cnt - fe0), 1);
    check("t4_idx", 32'(bit_index), DW - 1);
    bus_word(16'h00FF, 1'b1);
    bus_stop();
    check("t4_fe", 32'(fe_cnt - fe0), 1);
    check("t4_dv", 32'(dv_cnt - dv0), 1);

    // enable dropped mid-word, then clocks without START
    dv0 = dv_cnt; fe0 = fe_cnt;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(i[0] ^ i[1], 1'b0);
    STP_en = 1'b0;
    @(posedge clk);
    #1;
    check("t5_busy", 32'(busy), 0);
    check("t5_idx", 32'(bit_index), DW - 1);
    wait_ph();
    STP_en = 1'b1;
    wait_ph();
    bus_word(16'h5A5A, 1'b0);
    check("t5_ign_busy", 32'(busy), 0);
    check("t5_ign_idx", 32'(bit_index), DW - 1);
    check("t5_dv", 32'(dv_cnt - dv0), 0);
    check("t5_fe", 32'(fe_cnt - fe0), 0);

    // reset mid-word
    bus_start();
    for (int i = 5; i >= 0; i--) bus_bit(b6[i], 1'b0);
    fe0 = fe_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t6_data", 32'(data_out), 0);
    check("t6_dv", 32'(data_valid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_fe", 32'(frame_err), 0);
    check("t6_idx", 32'(bit_index), DW - 1);
    wait_ph();
    dv0 = dv_cnt;
    bus_start();
    bus_word(16'h8001, 1'b1);
    bus_stop();
    check("t6_fe_cnt", 32'(fe_cnt - fe0), 0);
    check("t6_dv_cnt", 32'(dv_cnt - dv0), 1);
    check("t6_word", 32'(data_out), 32'h 8001);

    wait_ph();
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
